// File: rtl/sha256_round_ctrl.sv
// ============================================================================
//  Module   : sha256_round_ctrl
//  Brief    : SHA-256 compression sequencer. Loads a..h from the H-bins, steps
//             64 rounds with COMP_EN, then folds a..h back into H.
//             Optional build macro SHA_CTRL_ABORT_EN adds an ABORT input that
//             cancels a block and restores H from a start-time snapshot.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sha256_round_ctrl #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      START,
    input  logic                      FIRST,
    input  logic                      LAST,
`ifdef SHA_CTRL_ABORT_EN
    input  logic                      ABORT,
`endif
    input  logic [WORD_W-1:0]         A_IN,
    input  logic [WORD_W-1:0]         B_IN,
    input  logic [WORD_W-1:0]         C_IN,
    input  logic [WORD_W-1:0]         D_IN,
    input  logic [WORD_W-1:0]         E_IN,
    input  logic [WORD_W-1:0]         F_IN,
    input  logic [WORD_W-1:0]         G_IN,
    input  logic [WORD_W-1:0]         H_IN,
    output logic                      COMP_RESET,
    output logic                      COMP_EN,
    output logic [$clog2(ROUNDS)-1:0] ROUND_I,
    output logic [WORD_W-1:0]         H0,
    output logic [WORD_W-1:0]         H1,
    output logic [WORD_W-1:0]         H2,
    output logic [WORD_W-1:0]         H3,
    output logic [WORD_W-1:0]         H4,
    output logic [WORD_W-1:0]         H5,
    output logic [WORD_W-1:0]         H6,
    output logic [WORD_W-1:0]         H7,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      DIGEST_VALID
);

    localparam int RI_W = $clog2(ROUNDS);
    localparam logic [RI_W-1:0] c_LAST_ROUND = RI_W'(ROUNDS - 1);

    localparam logic [WORD_W-1:0] c_IV [0:7] = '{
        WORD_W'(32'h6a09e667), WORD_W'(32'hbb67ae85),
        WORD_W'(32'h3c6ef372), WORD_W'(32'ha54ff53a),
        WORD_W'(32'h510e527f), WORD_W'(32'h9b05688c),
        WORD_W'(32'h1f83d9ab), WORD_W'(32'h5be0cd19)
    };

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ROUND  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RI_W-1:0]     r_round;
    logic [WORD_W-1:0]   r_h [0:7];
    logic [WORD_W-1:0]   w_in [0:7];
    logic                r_last;
    logic                r_dv;
    logic                w_accept;
    logic                w_abort;

    assign w_in[0] = A_IN;
    assign w_in[1] = B_IN;
    assign w_in[2] = C_IN;
    assign w_in[3] = D_IN;
    assign w_in[4] = E_IN;
    assign w_in[5] = F_IN;
    assign w_in[6] = G_IN;
    assign w_in[7] = H_IN;

    assign w_accept = (r_state == S_IDLE) && START;

`ifdef SHA_CTRL_ABORT_EN
    logic [WORD_W-1:0] r_h_snap [0:7];

    assign w_abort = ABORT && ((r_state == S_LOAD) || (r_state == S_ROUND) ||
                               (r_state == S_UPDATE));

    // Snapshot holds H as it stands once the block is accepted (after any IV load).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int n = 0; n < 8; n++) r_h_snap[n] <= c_IV[n];
        end else if (w_accept) begin
            for (int n = 0; n < 8; n++) r_h_snap[n] <= FIRST ? c_IV[n] : r_h[n];
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (START) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_ROUND;
            S_ROUND:  if (r_round == c_LAST_ROUND) w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int n = 0; n < 8; n++) r_h[n] <= c_IV[n];
            r_round <= '0;
            r_last  <= 1'b0;
            r_dv    <= 1'b0;
        end else if (w_abort) begin
`ifdef SHA_CTRL_ABORT_EN
            for (int n = 0; n < 8; n++) r_h[n] <= r_h_snap[n];
`endif
            r_round <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_last <= LAST;
                        r_dv   <= 1'b0;
                        if (FIRST) begin
                            for (int n = 0; n < 8; n++) r_h[n] <= c_IV[n];
                        end
                    end
                    r_round <= '0;
                end
                S_ROUND: begin
                    // Index returns to 0 only as the FSM leaves for UPDATE.
                    if (r_round == c_LAST_ROUND) r_round <= '0;
                    else                         r_round <= r_round + RI_W'(1);
                end
                S_UPDATE: begin
                    for (int n = 0; n < 8; n++) r_h[n] <= r_h[n] + w_in[n];
                    r_round <= '0;
                end
                S_DONE: begin
                    r_dv    <= r_last;
                    r_round <= '0;
                end
                default: r_round <= '0;
            endcase
        end
    end

    assign COMP_RESET   = (r_state == S_LOAD);
    assign COMP_EN      = (r_state == S_ROUND);
    assign BUSY         = (r_state != S_IDLE);
    assign DONE         = (r_state == S_DONE);
    assign ROUND_I      = r_round;
    assign DIGEST_VALID = r_dv;

    assign H0 = r_h[0];
    assign H1 = r_h[1];
    assign H2 = r_h[2];
    assign H3 = r_h[3];
    assign H4 = r_h[4];
    assign H5 = r_h[5];
    assign H6 = r_h[6];
    assign H7 = r_h[7];

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
// ============================================================================
//  Module   : tb_sha256_round_ctrl
//  Brief    : Self-checking bench for sha256_round_ctrl with a cycle-numbered
//             reference model of the block timing and H accumulation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sha256_round_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        first = 1'b0;
    logic        last = 1'b0;
`ifdef SHA_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic [31:0] din [8];
    logic        comp_reset, comp_en, busy, done, digest_valid;
    logic [5:0]  round_i;
    logic [31:0] h [8];

    logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] m_h [8];
    logic        m_dv;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .CLK(clk), .RESET(reset), .START(start), .FIRST(first), .LAST(last),
`ifdef SHA_CTRL_ABORT_EN
        .ABORT(abort),
`endif
        .A_IN(din[0]), .B_IN(din[1]), .C_IN(din[2]), .D_IN(din[3]),
        .E_IN(din[4]), .F_IN(din[5]), .G_IN(din[6]), .H_IN(din[7]),
        .COMP_RESET(comp_reset), .COMP_EN(comp_en), .ROUND_I(round_i),
        .H0(h[0]), .H1(h[1]), .H2(h[2]), .H3(h[3]),
        .H4(h[4]), .H5(h[5]), .H6(h[6]), .H7(h[7]),
        .BUSY(busy), .DONE(done), .DIGEST_VALID(digest_valid)
    );

    // Runs one block from the IDLE negedge; cycle c counts negedges after acceptance.
    // START is re-pulsed during cycles pa/pb (0 = none) to show it is ignored.
    task automatic do_block(input bit f, input bit l, input int pa, input int pb);
        start = 1'b1; first = f; last = l;
        @(posedge clk);
        if (f) m_h = iv;
        m_dv = 1'b0;
        #1 start = 1'b0; first = 1'($urandom); last = 1'($urandom);
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            start = (c == pa) || (c == pb);
            checks++;
            if (comp_reset !== (c == 1)) begin
                errors++; $display("FAIL comp_reset c=%0d got %b want %b", c, comp_reset, c == 1);
            end
            checks++;
            if (comp_en !== (c >= 2 && c <= 65)) begin
                errors++; $display("FAIL comp_en c=%0d got %b want %b", c, comp_en, c >= 2 && c <= 65);
            end
            checks++;
            if (busy !== (c <= 67)) begin
                errors++; $display("FAIL busy c=%0d got %b want %b", c, busy, c <= 67);
            end
            checks++;
            if (done !== (c == 67)) begin
                errors++; $display("FAIL done c=%0d got %b want %b", c, done, c == 67);
            end
            if (c >= 1 && c <= 65) begin
                checks++;
                if (round_i !== ((c == 1) ? 6'd0 : 6'(c - 2))) begin
                    errors++; $display("FAIL round_i c=%0d got %0d want %0d", c, round_i, (c == 1) ? 0 : c - 2);
                end
            end
            if (c == 1) begin
                checks++;
                if (digest_valid !== 1'b0) begin
                    errors++; $display("FAIL dv_clear got %b want 0", digest_valid);
                end
            end
            if (c == 67) begin
                for (int n = 0; n < 8; n++) m_h[n] = m_h[n] + din[n];
                for (int n = 0; n < 8; n++) begin
                    checks++;
                    if (h[n] !== m_h[n]) begin
                        errors++; $display("FAIL h_update H%0d got %h want %h", n, h[n], m_h[n]);
                    end
                end
            end
            if (c == 68) begin
                m_dv = l;
                checks++;
                if (digest_valid !== m_dv) begin
                    errors++; $display("FAIL digest_valid got %b want %b", digest_valid, m_dv);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_h = iv; m_dv = 1'b0;
        checks++;
        if ({busy, done, digest_valid, comp_en, comp_reset} !== 5'b0 || round_i !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl got b%b d%b v%b e%b r%b i%0d want all 0",
                               busy, done, digest_valid, comp_en, comp_reset, round_i);
        end
        checks++;
        if (h[0] !== 32'h6a09e667 || h[7] !== 32'h5be0cd19) begin
            errors++; $display("FAIL reset_h got %h/%h want 6a09e667/5be0cd19", h[0], h[7]);
        end
    endtask

    task automatic test_single_block();
        for (int n = 0; n < 8; n++) din[n] = 32'hFFFFFFFF;
        do_block(1'b1, 1'b1, 0, 0);
        checks++;
        if (h[0] !== 32'h6a09e666 || h[7] !== 32'h5be0cd18 || digest_valid !== 1'b1) begin
            errors++; $display("FAIL single_block got %h/%h v%b want 6a09e666/5be0cd18 v1",
                               h[0], h[7], digest_valid);
        end
    endtask

    task automatic test_multi_block();
        for (int n = 0; n < 8; n++) din[n] = 32'h1;
        do_block(1'b1, 1'b0, 0, 0);
        checks++;
        if (h[0] !== 32'h6a09e668 || digest_valid !== 1'b0) begin
            errors++; $display("FAIL multi_blk1 got %h v%b want 6a09e668 v0", h[0], digest_valid);
        end
        do_block(1'b0, 1'b1, 0, 0);
        checks++;
        if (h[0] !== 32'h6a09e669 || digest_valid !== 1'b1) begin
            errors++; $display("FAIL multi_blk2 got %h v%b want 6a09e669 v1", h[0], digest_valid);
        end
    endtask

    task automatic test_start_ignored();
        for (int n = 0; n < 8; n++) din[n] = $urandom;
        do_block(1'b1, 1'b1, 10, 67);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL start_queued busy got %b want 0", busy);
        end
    endtask

    task automatic test_random_chain();
        for (int b = 0; b < 6; b++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || h[0] !== m_h[0]) begin
                    errors++; $display("FAIL idle_hold busy %b h0 %h want 0 %h", busy, h[0], m_h[0]);
                end
            end
            for (int n = 0; n < 8; n++) din[n] = $urandom;
            do_block((b == 0) ? 1'b1 : 1'($urandom), 1'($urandom),
                     $urandom_range(2, 67), $urandom_range(2, 67));
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; first = 1'b1; last = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 32; c++) @(negedge clk);
        checks++;
        if (round_i !== 6'd30) begin
            errors++; $display("FAIL mid_round_i got %0d want 30", round_i);
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_h = iv; m_dv = 1'b0;
        checks++;
        if (busy !== 1'b0 || comp_en !== 1'b0 || round_i !== 6'd0 || digest_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ctrl got b%b e%b i%0d v%b want 0", busy, comp_en, round_i, digest_valid);
        end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (h[n] !== iv[n]) begin
                errors++; $display("FAIL mid_reset_h H%0d got %h want %h", n, h[n], iv[n]);
            end
        end
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL mid_reset_done got 1 want 0 at %0d", c);
            end
        end
    endtask

`ifdef SHA_CTRL_ABORT_EN
    task automatic test_abort();
        din[0] = 32'h12345678 - iv[0];
        for (int n = 1; n < 8; n++) din[n] = $urandom;
        do_block(1'b1, 1'b0, 0, 0);
        checks++;
        if (h[0] !== 32'h12345678) begin
            errors++; $display("FAIL abort_setup got %h want 12345678", h[0]);
        end
        for (int k = 0; k < 2; k++) begin
            int stop_c;
            stop_c = (k == 0) ? 42 : 66;
            for (int n = 0; n < 8; n++) din[n] = $urandom;
            start = 1'b1; first = 1'b0; last = 1'b1;
            @(posedge clk);
            m_dv = 1'b0;
            #1 start = 1'b0;
            for (int c = 1; c <= stop_c; c++) @(negedge clk);
            if (k == 0) begin
                checks++;
                if (round_i !== 6'd40) begin
                    errors++; $display("FAIL abort_round_i got %0d want 40", round_i);
                end
            end
            abort = 1'b1;
            @(negedge clk); abort = 1'b0;
            checks++;
            if (busy !== 1'b0 || comp_en !== 1'b0 || round_i !== 6'd0 || done !== 1'b0) begin
                errors++; $display("FAIL abort_ctrl k%0d got b%b e%b i%0d d%b want 0", k, busy, comp_en, round_i, done);
            end
            for (int n = 0; n < 8; n++) begin
                checks++;
                if (h[n] !== m_h[n]) begin
                    errors++; $display("FAIL abort_h k%0d H%0d got %h want %h", k, n, h[n], m_h[n]);
                end
            end
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || h[0] !== 32'h12345678) begin
            errors++; $display("FAIL abort_idle got b%b %h want 0 12345678", busy, h[0]);
        end
        for (int n = 0; n < 8; n++) din[n] = $urandom;
        do_block(1'b0, 1'b1, 0, 0);
    endtask
`endif

    initial begin
        for (int n = 0; n < 8; n++) din[n] = '0;
        m_h = iv; m_dv = 1'b0;
        test_reset();
        test_single_block();
        test_multi_block();
        test_start_ignored();
        test_random_chain();
        test_reset_mid();
`ifdef SHA_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
